// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//
// Purpose:
//   Elastic pipeline register that sits between two pipeline stages
//   (F/D, D/E, E/M, M/W). It moves entries with a valid/ready handshake
//   and has a forward latency of one cycle.
//
//   SKID=1 adds a second (skid) register. With it, in_ready can come from a
//   flop, so the ready path does not depend on out_ready. SKID=0 keeps a
//   single register, and in_ready is then combinational.
//
//   flush, hold and bubble let the pipeline control redirect, freeze and
//   hazard stalls. Their priority is rst > flush > hold > bubble > normal.
//
//   The control field reads as zero whenever no valid entry is presented,
//   so a stalled or emptied stage looks like a NOP downstream.
//
//   A saturating counter records every cycle in which a bubble turns away a
//   valid upstream entry.
//
// Ports:
//   clk         in   1       clock, rising edge
//   rst         in   1       asynchronous, active-high reset
//   in_valid    in   1       upstream entry valid
//   in_ready    out  1       stage accepts an entry this cycle
//   in_ctrl     in   CTRL_W  control payload
//   in_data     in   DATA_W  data payload
//   flush       in   1       drop all held entries and the current input
//   bubble      in   1       refuse input this cycle (load-use hazard)
//   hold        in   1       global freeze of state, payloads and counter
//   out_valid   out  1       entry presented downstream
//   out_ready   in   1       downstream accepts
//   out_ctrl    out  CTRL_W  control payload, 0 when out_valid=0
//   out_data    out  DATA_W  data payload (zeroed when invalid if CLEAR_DATA)
//   occupancy   out  2       entries held (0..2)
//   bubble_cnt  out  CNT_W   saturating count of bubble refusals
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  input  logic              bubble,
  input  logic              hold,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  // Registered part of in_ready.
  // SKID=1: "next state is not TWO", captured at the previous edge.
  // SKID=0: only marks that the stage is out of reset.
  // Either way it is 0 while rst is asserted.
  logic              rdy_q;

  logic              accept_ok;
  logic              in_fire;
  logic              out_fire;
  logic              load_main;
  logic              main_from_skid;
  logic              load_skid;
  logic              cnt_inc;

  logic [CTRL_W-1:0] main_ctrl;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [DATA_W-1:0] skid_data;
  logic [CNT_W-1:0]  cnt;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  // in_fire is already 0 under flush/hold/bubble, and out_fire is 0 under
  // hold. So only flush and hold need explicit terms here.
  // NOTE: every always_comb output gets a default first; without it a
  // missed branch infers a latch.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = EMPTY;
    end else if (!hold) begin
      case (state)
        EMPTY: begin
          if (in_fire) state_nxt = ONE;
        end
        ONE: begin
          if (in_fire && !out_fire) begin
            // Unreachable with SKID=0: in_ready there demands out_ready.
            state_nxt = (SKID != 0) ? TWO : ONE;
          end else if (!in_fire && out_fire) begin
            state_nxt = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs
  // -------------------------------------------------------------------------
  always_comb begin
    accept_ok = !hold && !bubble && !flush;
    if (SKID != 0) begin
      in_ready = rdy_q && accept_ok;
    end else begin
      in_ready = rdy_q && ((state == EMPTY) || out_ready) && accept_ok;
    end
    out_valid = (state != EMPTY) && !hold;
    case (state)
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q <= 1'b0;
    end else if (SKID != 0) begin
      rdy_q <= (state_nxt != TWO);
    end else begin
      rdy_q <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Payload registers
  // -------------------------------------------------------------------------
  // The main register loads from the input when:
  //   - the stage is empty, or
  //   - the current entry leaves in the same cycle.
  // It refills from skid when TWO drains.
  // The flush gate on the skid move keeps out_data from showing a discarded
  // entry when CLEAR_DATA=0.
  assign load_main      = in_fire && ((state == EMPTY) || ((state == ONE) && out_fire));
  assign main_from_skid = (state == TWO) && out_fire && !flush;
  assign load_skid      = (SKID != 0) && in_fire && (state == ONE) && !out_fire;

  // NOTE: payload registers are reset too. That way out_data reads 0 after
  // reset and no stale partial entry can reach the outputs after an rst
  // mid-transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  assign out_ctrl = out_valid ? main_ctrl : '0;
  assign out_data = ((CLEAR_DATA != 0) && !out_valid) ? '0 : main_data;

  // -------------------------------------------------------------------------
  // Bubble counter: saturating, cleared only by rst
  // -------------------------------------------------------------------------
  assign cnt_inc = bubble && in_valid && !hold && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bubble_cnt = cnt;

`ifndef SYNTHESIS
  // The stage must never accept while full, and must never report two
  // entries without a skid register.
  a_no_accept_when_full: assert property (@(posedge clk) disable iff (rst)
    !((state == TWO) && in_fire));
  a_two_needs_skid: assert property (@(posedge clk) disable iff (rst)
    !((SKID == 0) && (state == TWO)));
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//
// Directed bench for pipe_stage_reg.
//
// The main instance uses SKID=1, CLEAR_DATA=0 and CNT_W=2, so counter
// saturation is reachable. A second instance (SKID=0, CLEAR_DATA=1) shares
// the same inputs and is checked where its behaviour differs: the
// combinational in_ready and the zeroed out_data.
//
// All expected values are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 2;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              bubble;
  logic              hold;
  logic              out_ready;

  logic              in_ready;
  logic              out_valid;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              in_ready0;
  logic              out_valid0;
  logic [CTRL_W-1:0] out_ctrl0;
  logic [DATA_W-1:0] out_data0;
  logic [1:0]        occupancy0;
  logic [CNT_W-1:0]  bubble_cnt0;

  int n_checks;
  int n_pass;

  pipe_stage_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(1), .CLEAR_DATA(0), .CNT_W(CNT_W)
  ) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush), .bubble(bubble), .hold(hold),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
    .occupancy(occupancy), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .SKID(0), .CLEAR_DATA(1), .CNT_W(CNT_W)
  ) u_dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready0), .in_ctrl(in_ctrl), .in_data(in_data),
    .flush(flush), .bubble(bubble), .hold(hold),
    .out_valid(out_valid0), .out_ready(out_ready), .out_ctrl(out_ctrl0), .out_data(out_data0),
    .occupancy(occupancy0), .bubble_cnt(bubble_cnt0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ctrl   = '0;
    in_data   = '0;
    flush     = 1'b0;
    bubble    = 1'b0;
    hold      = 1'b0;
    out_ready = 1'b0;

    // ---------------- reset state ----------------
    tick();
    tick();
    check("rst_in_ready",   in_ready,   0);
    check("rst_in_ready0",  in_ready0,  0);
    check("rst_out_valid",  out_valid,  0);
    check("rst_out_ctrl",   out_ctrl,   0);
    check("rst_out_data",   out_data,   0);
    check("rst_occupancy",  occupancy,  0);
    check("rst_bubble_cnt", bubble_cnt, 0);
    rst = 1'b0;
    tick();
    check("post_rst_in_ready",  in_ready,  1);
    check("post_rst_in_ready0", in_ready0, 1);

    // ---------------- streaming 1..8 ----------------
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_ctrl  = CTRL_W'(i);
      in_data  = DATA_W'(i) * 32'h11;
      #1;
      check($sformatf("stream_in_ready_%0d", i), in_ready, 1);
      tick();
      check($sformatf("stream_valid_%0d", i), out_valid, 1);
      check($sformatf("stream_ctrl_%0d", i),  out_ctrl,  i);
      check($sformatf("stream_data_%0d", i),  out_data,  i * 32'h11);
      check($sformatf("stream_ctrl0_%0d", i), out_ctrl0, i);
    end
    in_valid = 1'b0;
    tick();
    check("stream_drain_valid", out_valid, 0);
    check("stream_drain_ctrl",  out_ctrl,  0);
    check("stream_drain_occ",   occupancy, 0);
    check("stream_keep_data",   out_data,  32'h88);
    check("stream_clear_data0", out_data0, 0);

    // ---------------- backpressure (skid) ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'd5;
    in_data   = 32'h55;
    tick();
    check("bp_occ1",  occupancy, 1);
    check("bp_ctrl5", out_ctrl,  5);
    in_ctrl = 16'd6;
    in_data = 32'h66;
    #1;
    check("bp_in_ready_one",  in_ready,  1);
    check("bp_in_ready0_one", in_ready0, 0);
    tick();
    in_valid = 1'b0;
    #1;
    check("bp_occ2",        occupancy, 2);
    check("bp_in_ready_two", in_ready, 0);
    check("bp_head_ctrl",   out_ctrl,  5);
    check("bp_head_data",   out_data,  32'h55);
    out_ready = 1'b1;
    #1;
    check("bp_deliver5", out_ctrl, 5);
    tick();
    check("bp_deliver6",     out_ctrl,  6);
    check("bp_deliver6_dat", out_data,  32'h66);
    check("bp_occ_back1",    occupancy, 1);
    check("bp_ready_back",   in_ready,  1);
    tick();
    check("bp_empty_valid", out_valid, 0);
    check("bp_empty_occ",   occupancy, 0);

    // ---------------- flush ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'd1;
    in_data   = 32'h1;
    tick();
    in_ctrl = 16'd2;
    in_data = 32'h2;
    tick();
    check("fl_occ2", occupancy, 2);
    flush   = 1'b1;
    in_ctrl = 16'd9;
    in_data = 32'h99;
    #1;
    check("fl_in_ready", in_ready, 0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("fl_valid",    out_valid, 0);
    check("fl_ctrl",     out_ctrl,  0);
    check("fl_occ",      occupancy, 0);
    check("fl_ready",    in_ready,  1);
    check("fl_valid0",   out_valid0, 0);
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("fl_no9_%0d", k), out_valid, 0);
    end

    // ---------------- bubble ----------------
    in_valid = 1'b1;
    in_ctrl  = 16'd3;
    in_data  = 32'h33;
    tick();
    check("bub_head3", out_ctrl, 3);
    bubble  = 1'b1;
    in_ctrl = 16'd4;
    in_data = 32'h44;
    for (int k = 1; k <= 3; k++) begin
      #1;
      check($sformatf("bub_in_ready_%0d", k), in_ready, 0);
      tick();
      check($sformatf("bub_cnt_%0d", k),   bubble_cnt, k);
      check($sformatf("bub_valid_%0d", k), out_valid,  0);
      check($sformatf("bub_ctrl_%0d", k),  out_ctrl,   0);
    end
    bubble = 1'b0;
    tick();
    check("bub_after_ctrl4", out_ctrl,   4);
    check("bub_after_cnt",   bubble_cnt, 3);
    in_valid = 1'b0;
    tick();
    check("bub_drain", out_valid, 0);

    // ---------------- hold ----------------
    in_valid = 1'b1;
    in_ctrl  = 16'd7;
    in_data  = 32'h77;
    tick();
    check("hold_pre_ctrl7", out_ctrl, 7);
    in_valid = 1'b0;
    hold     = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check($sformatf("hold_valid_%0d", k), out_valid, 0);
      check($sformatf("hold_ctrl_%0d", k),  out_ctrl,  0);
      check($sformatf("hold_occ_%0d", k),   occupancy, 1);
      check($sformatf("hold_ready_%0d", k), in_ready,  0);
    end
    hold = 1'b0;
    #1;
    check("hold_rel_valid", out_valid, 1);
    check("hold_rel_ctrl",  out_ctrl,  7);
    check("hold_rel_data",  out_data,  32'h77);
    tick();
    check("hold_drain", out_valid, 0);

    // ---------------- async reset mid-stream ----------------
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 16'd1;
    tick();
    in_ctrl = 16'd2;
    tick();
    in_valid = 1'b0;
    check("rs_occ2", occupancy, 2);
    rst = 1'b1;
    #1;
    check("rs_valid", out_valid,  0);
    check("rs_ctrl",  out_ctrl,   0);
    check("rs_data",  out_data,   0);
    check("rs_occ",   occupancy,  0);
    check("rs_ready", in_ready,   0);
    check("rs_cnt",   bubble_cnt, 0);
    tick();
    rst = 1'b0;
    tick();
    check("rs_ready_back", in_ready,  1);
    check("rs_valid_back", out_valid, 0);
    out_ready = 1'b1;
    for (int i = 10; i <= 11; i++) begin
      in_valid = 1'b1;
      in_ctrl  = CTRL_W'(i);
      tick();
      check($sformatf("rs_stream_%0d", i), out_ctrl, i);
    end
    in_valid = 1'b0;
    tick();
    check("rs_stream_drain", out_valid, 0);

    // ---------------- bubble counter gating and saturation ----------------
    bubble   = 1'b1;
    in_valid = 1'b1;
    hold     = 1'b1;
    tick();
    check("cnt_hold_masks", bubble_cnt, 0);
    hold  = 1'b0;
    flush = 1'b1;
    tick();
    check("cnt_flush_masks", bubble_cnt, 0);
    flush = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("cnt_sat_%0d", k), bubble_cnt, (k > 3) ? 3 : k);
    end
    bubble   = 1'b0;
    in_valid = 1'b0;
    tick();
    check("cnt_sat_hold", bubble_cnt, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
